// File: rtl/approx_err_pkg.sv
// approx_err_pkg: shared widths, FSM state type and accumulator sizing for the approximate-sum error monitor
package approx_err_pkg;
  localparam int ED_W = 17;
  localparam int OPND_W = 16;
  typedef enum logic [1:0] {ACCUM, DRAIN, REPORT} state_t;
  function automatic int acc_w(input int win_w);
    return ED_W + win_w;
  endfunction
endpackage

// File: rtl/approx_err_distance.sv
// approx_err_distance: exact 17-bit sum vs adder's {carry, Sum}; returns |error| and signed (approx - exact)
module approx_err_distance
  import approx_err_pkg::*;
(
  input  logic [OPND_W-1:0]      op_a,
  input  logic [OPND_W-1:0]      op_b,
  input  logic [OPND_W-1:0]      approx_sum,
  input  logic                   approx_carry,
  output logic [ED_W-1:0]        ed,
  output logic signed [ED_W:0]   diff
);
  logic [ED_W-1:0] exact;
  logic [ED_W-1:0] approx;
  // one extra bit on the difference keeps the full -0x1FFFF..+0x1FFFF range, so |diff| never truncates
  always_comb begin
    exact = {1'b0, op_a} + {1'b0, op_b};
    approx = {approx_carry, approx_sum};
    diff = $signed({1'b0, approx}) - $signed({1'b0, exact});
    ed = diff[ED_W] ? ED_W'(-diff) : diff[ED_W-1:0];
  end
endmodule

// File: rtl/approx_sum_error_monitor.sv
// approx_sum_error_monitor: windowed error-distance statistics for a 16-bit approximate adder; APPROX_ERR_BIAS_EN adds signed bias output err_bias
module approx_sum_error_monitor
  import approx_err_pkg::*;
#(
  parameter int WINDOW = 256,
  parameter int WIN_W = $clog2(WINDOW)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OPND_W-1:0]          op_a,
  input  logic [OPND_W-1:0]          op_b,
  input  logic [OPND_W-1:0]          approx_sum,
  input  logic                       approx_carry,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIN_W:0]             err_count,
`ifdef APPROX_ERR_BIAS_EN
  output logic signed [ED_W+WIN_W:0] err_bias,
`endif
  output logic [ED_W+WIN_W-1:0]      err_total,
  output logic [ED_W-1:0]            err_max
);
  localparam int ACC_W = acc_w(WIN_W);
  localparam int CNT_W = WIN_W + 1;
  state_t state;
  logic [WIN_W-1:0] cnt;
  logic accept;
  logic last;
  logic [ED_W-1:0] ed;
  logic signed [ED_W:0] diff;
  logic s1_valid;
  logic s1_last;
  logic s1_nz;
  logic [ED_W-1:0] s1_ed;
`ifdef APPROX_ERR_BIAS_EN
  logic signed [ED_W:0] s1_diff;
`endif
  assign accept = in_valid && in_ready;
  assign last = cnt == WIN_W'(WINDOW - 1);
  approx_err_distance u_dist (
    .op_a         (op_a),
    .op_b         (op_b),
    .approx_sum   (approx_sum),
    .approx_carry (approx_carry),
    .ed           (ed),
    .diff         (diff)
  );
  // stage 1: capture ED of an accepted sample; the nonzero flag is precomputed here to keep stage 2 short
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last <= 1'b0;
      s1_nz <= 1'b0;
      s1_ed <= '0;
    end else begin
      s1_valid <= accept;
      s1_last <= accept && last;
      s1_nz <= diff != '0;
      s1_ed <= ed;
    end
  end
`ifdef APPROX_ERR_BIAS_EN
  // stage 1: signed difference travels alongside ED for the bias accumulator
  always_ff @(posedge clk) begin
    if (!rst_n) s1_diff <= '0;
    else s1_diff <= diff;
  end
`endif
  // window control: count accepted samples, drain the last one, then hold the report until it is taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ACCUM;
      cnt <= '0;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept && last) begin
            state <= DRAIN;
            in_ready <= 1'b0;
          end else if (accept) begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (s1_last) begin
            state <= REPORT;
            out_valid <= 1'b1;
          end
        end
        REPORT: begin
          if (out_ready) begin
            state <= ACCUM;
            cnt <= '0;
            in_ready <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state <= ACCUM;
          cnt <= '0;
          in_ready <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
  // stage 2: fold the registered ED into the window statistics; cleared when the report is taken
  always_ff @(posedge clk) begin
    if (!rst_n || (out_valid && out_ready)) begin
      err_count <= '0;
      err_total <= '0;
      err_max <= '0;
    end else if (s1_valid) begin
      err_count <= err_count + CNT_W'(s1_nz);
      err_total <= err_total + ACC_W'(s1_ed);
      err_max <= s1_ed > err_max ? s1_ed : err_max;
    end
  end
`ifdef APPROX_ERR_BIAS_EN
  // stage 2: signed running sum exposes systematic over- or under-estimation
  always_ff @(posedge clk) begin
    if (!rst_n || (out_valid && out_ready)) err_bias <= '0;
    else if (s1_valid) err_bias <= err_bias + (ACC_W + 1)'(s1_diff);
  end
`endif
endmodule

// File: tb/tb_approx_sum_error_monitor.sv
// tb_approx_sum_error_monitor: table-driven windows with a report scoreboard plus backpressure and reset sequences
module tb_approx_sum_error_monitor;
  localparam int WINDOW = 4;
  localparam int WIN_W = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic [15:0] approx_sum = '0;
  logic approx_carry = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [WIN_W:0] err_count;
  logic [16+WIN_W:0] err_total;
  logic [16:0] err_max;
`ifdef APPROX_ERR_BIAS_EN
  logic signed [17+WIN_W:0] err_bias;
`endif
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s;
    logic c;
  } smp_t;
  typedef struct packed {
    logic [WIN_W:0] cnt;
    logic [16+WIN_W:0] total;
    logic [16:0] max;
    logic signed [17+WIN_W:0] bias;
  } rep_t;
  typedef struct {
    string name;
    smp_t s[WINDOW];
    rep_t r;
  } win_t;
  win_t tbl[5];
  rep_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  approx_sum_error_monitor #(.WINDOW(WINDOW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .approx_sum   (approx_sum),
    .approx_carry (approx_carry),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .err_count    (err_count),
`ifdef APPROX_ERR_BIAS_EN
    .err_bias     (err_bias),
`endif
    .err_total    (err_total),
    .err_max      (err_max)
  );
  function automatic smp_t mk(input logic [15:0] a, input logic [15:0] b, input logic [15:0] s, input logic c);
    return {a, b, s, c};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic send(input smp_t v);
    int t = 0;
    @(negedge clk);
    {op_a, op_b, approx_sum, approx_carry} = v;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send in_ready timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic get_report(input string nm);
    int t = 0;
    rep_t r;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) begin
      chk({nm, " out_valid timeout"}, 64'(out_valid), 64'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      chk({nm, " unexpected report"}, 64'd1, 64'd0);
      return;
    end
    r = exp_q.pop_front();
    chk({nm, " err_count"}, 64'(err_count), 64'(r.cnt));
    chk({nm, " err_total"}, 64'(err_total), 64'(r.total));
    chk({nm, " err_max"}, 64'(err_max), 64'(r.max));
`ifdef APPROX_ERR_BIAS_EN
    chk({nm, " err_bias"}, 64'(err_bias), 64'(r.bias));
`endif
    chk({nm, " in_ready in report"}, 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " in_ready after handshake"}, 64'(in_ready), 64'd1);
    chk({nm, " out_valid after handshake"}, 64'(out_valid), 64'd0);
    chk({nm, " err_total cleared"}, 64'(err_total), 64'd0);
  endtask
  task automatic run_win(input int i);
    exp_q.push_back(tbl[i].r);
    for (int j = 0; j < WINDOW; j++) send(tbl[i].s[j]);
    get_report(tbl[i].name);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0].name = "exact";
    tbl[0].s[0] = mk(16'd1, 16'd2, 16'd3, 1'b0);
    tbl[0].s[1] = mk(16'hFFFF, 16'd1, 16'h0000, 1'b1);
    tbl[0].s[2] = mk(16'd5, 16'd5, 16'd10, 1'b0);
    tbl[0].s[3] = mk(16'd0, 16'd0, 16'd0, 1'b0);
    tbl[0].r = '{3'd0, 19'd0, 17'd0, 20'sd0};
    tbl[1].name = "one_err";
    tbl[1].s[0] = mk(16'h000F, 16'h0001, 16'h0000, 1'b0);
    tbl[1].s[1] = mk(16'd1, 16'd2, 16'd3, 1'b0);
    tbl[1].s[2] = mk(16'd5, 16'd5, 16'd10, 1'b0);
    tbl[1].s[3] = mk(16'd0, 16'd0, 16'd0, 1'b0);
    tbl[1].r = '{3'd1, 19'd16, 17'd16, -20'sd16};
    tbl[2].name = "worst";
    for (int j = 0; j < WINDOW; j++) tbl[2].s[j] = mk(16'hFFFF, 16'hFFFF, 16'h0000, 1'b0);
    tbl[2].r = '{3'd4, 19'h7FFF8, 17'h1FFFE, -20'sd524280};
    tbl[3].name = "bias_mix";
    tbl[3].s[0] = mk(16'h000F, 16'h0001, 16'h0000, 1'b0);
    tbl[3].s[1] = mk(16'd1, 16'd1, 16'd5, 1'b0);
    tbl[3].s[2] = mk(16'd1, 16'd2, 16'd3, 1'b0);
    tbl[3].s[3] = mk(16'd0, 16'd0, 16'd0, 1'b0);
    tbl[3].r = '{3'd2, 19'd19, 17'd16, -20'sd13};
    tbl[4].name = "over_carry";
    tbl[4].s[0] = mk(16'd7, 16'd9, 16'd16, 1'b0);
    tbl[4].s[1] = mk(16'h8000, 16'h8000, 16'hFFFF, 1'b1);
    tbl[4].s[2] = mk(16'd5, 16'd5, 16'd10, 1'b0);
    tbl[4].s[3] = mk(16'hFFFF, 16'd1, 16'h0000, 1'b1);
    tbl[4].r = '{3'd1, 19'h0FFFF, 17'h0FFFF, 20'sd65535};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset err_count", 64'(err_count), 64'd0);
    chk("reset err_total", 64'(err_total), 64'd0);
    chk("reset err_max", 64'(err_max), 64'd0);
    out_ready = 1'b1;
    run_win(0);
    for (int i = 1; i < 5; i++) run_win(i);
    exp_q.push_back(tbl[1].r);
    for (int j = 0; j < WINDOW; j++) send(tbl[1].s[j]);
    for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      {op_a, op_b, approx_sum, approx_carry} = mk(16'hFFFF, 16'hFFFF, 16'h0000, 1'b0);
      in_valid = 1'b1;
      chk("hold in_ready", 64'(in_ready), 64'd0);
      chk("hold out_valid", 64'(out_valid), 64'd1);
      chk("hold err_total", 64'(err_total), 64'(tbl[1].r.total));
      chk("hold err_max", 64'(err_max), 64'(tbl[1].r.max));
      @(negedge clk);
    end
    in_valid = 1'b0;
    get_report("backpressure");
    run_win(0);
    send(tbl[2].s[0]);
    send(tbl[2].s[1]);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset in_ready", 64'(in_ready), 64'd1);
    chk("midreset out_valid", 64'(out_valid), 64'd0);
    chk("midreset err_count", 64'(err_count), 64'd0);
    chk("midreset err_total", 64'(err_total), 64'd0);
    chk("midreset err_max", 64'(err_max), 64'd0);
    run_win(1);
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
